// File: rtl/cmat_pkg.sv
// -----------------------------------------------------------------------------
// cmat_pkg
//   Shared definitions for the complex-matrix datapath: matrix geometry
//   (4 rows x 2 cols = 8 entries), the address type, the read-side FSM state
//   encoding of the ping-pong buffer, and the {row, col} address packing
//   helper used by the buffer and by the trace/metric calculators.
// -----------------------------------------------------------------------------
package cmat_pkg;

  localparam int CMAT_ROWS   = 4;
  localparam int CMAT_COLS   = 2;
  localparam int CMAT_DEPTH  = CMAT_ROWS * CMAT_COLS;
  localparam int CMAT_ADDR_W = 3;

  typedef logic [CMAT_ADDR_W-1:0] cmat_addr_t;

  // Read-side sequencing: wait for a full bank, announce it, hold it until
  // the calculator reports completion.
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_BUSY  = 2'd2
  } rd_state_e;

  // Row-major packing: entry (row, col) lives at address {row, col}.
  function automatic cmat_addr_t cmat_addr(input logic [1:0] row, input logic col);
    return {row, col};
  endfunction

endpackage

// File: rtl/cmat_bank.sv
// -----------------------------------------------------------------------------
// cmat_bank
//   One 8-entry complex register file (real and imaginary halves kept in
//   separate arrays). Synchronous write, asynchronous (combinational) read,
//   synchronous clear of every entry on rst.
//
// Ports
//   clk, rst            clock, synchronous active-high reset (clears contents)
//   we                  write enable
//   waddr               write address {row, col}
//   wdata_r, wdata_i    write data, signed real / imaginary
//   raddr               read address {row, col}
//   rdata_r, rdata_i    read data, valid in the same cycle as raddr
// -----------------------------------------------------------------------------
module cmat_bank
  import cmat_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  cmat_addr_t          waddr,
  input  logic signed [N-1:0] wdata_r,
  input  logic signed [N-1:0] wdata_i,
  input  cmat_addr_t          raddr,
  output logic signed [N-1:0] rdata_r,
  output logic signed [N-1:0] rdata_i
);

  logic signed [N-1:0] mem_r [CMAT_DEPTH];
  logic signed [N-1:0] mem_i [CMAT_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this is a small flop-based register file, not a RAM macro, so
      // clearing every entry is cheap and gives a defined rd_data after reset.
      for (int k = 0; k < CMAT_DEPTH; k++) begin
        mem_r[k] <= '0;
        mem_i[k] <= '0;
      end
    end else if (we) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      mem_r[waddr] <= wdata_r;
      mem_i[waddr] <= wdata_i;
    end
  end

  // The calculator consumes data in its address cycle: no read register.
  assign rdata_r = mem_r[raddr];
  assign rdata_i = mem_i[raddr];

endmodule

// File: rtl/cmat_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// cmat_pingpong_buffer
//   Two-bank store for one 4x2 complex matrix. The write side fills one bank
//   from a valid/ready sample stream (8 beats, s_last on the 8th); the read
//   side exposes the other bank to the calculator through a combinational
//   address/data port. When a bank becomes full the calculator is kicked with
//   a one-cycle start_calc; its done_calc pulse frees the bank.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   s_valid / s_ready     write-stream handshake
//   s_data_r / s_data_i   sample, signed real / imaginary
//   s_last                marks the 8th sample of a matrix
//   rd_addr               calculator read address {row, col}
//   rd_data_r / rd_data_i entry rd_addr of the read bank (same cycle)
//   start_calc            one-cycle pulse: read bank holds a full matrix
//   done_calc             calculator finished with the read bank
//   occupancy             number of full banks (0..2)
//   err_frame             one-cycle pulse: s_last misplaced, frame dropped
// -----------------------------------------------------------------------------
module cmat_pingpong_buffer
  import cmat_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = CMAT_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [N-1:0] s_data_r,
  input  logic signed [N-1:0] s_data_i,
  input  logic                s_last,
  input  cmat_addr_t          rd_addr,
  output logic signed [N-1:0] rd_data_r,
  output logic signed [N-1:0] rd_data_i,
  output logic                start_calc,
  input  logic                done_calc,
  output logic [1:0]          occupancy,
  output logic                err_frame
);

  localparam cmat_addr_t LAST_PTR = cmat_addr_t'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic       wr_bank;
  cmat_addr_t wr_ptr;
  logic       rd_bank;
  logic [1:0] full;
  rd_state_e  rd_state;

  // ---------------------------------------------------------------------------
  // Write-side decode. s_ready depends on registers only, so the upstream
  // producer never sees a combinational path from s_valid back to s_ready.
  // ---------------------------------------------------------------------------
  logic accept;
  logic ptr_last;
  logic commit;
  logic frame_bad;
  logic release_bank;

  assign s_ready   = ~full[wr_bank];
  assign accept    = s_valid & s_ready;
  assign ptr_last  = (wr_ptr == LAST_PTR);
  assign commit    = accept & s_last & ptr_last;
  // s_last early, or missing on the 8th beat: drop the frame.
  assign frame_bad = accept & (s_last ^ ptr_last);

  // done_calc only counts once the calculator has been started.
  assign release_bank = (rd_state == R_BUSY) & done_calc;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_ptr    <= '0;
      err_frame <= 1'b0;
    end else begin
      err_frame <= frame_bad;
      if (accept) begin
        // Any s_last, or the 8th beat, closes the frame; a bad frame simply
        // leaves the bank unmarked so the next frame overwrites it.
        wr_ptr <= (s_last | ptr_last) ? '0 : wr_ptr + cmat_addr_t'(1);
        if (commit) begin
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Full flags. A commit targets wr_bank (not full) and a release targets
  // rd_bank (full), so the two never hit the same bank in one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (commit && (wr_bank == 1'(b))) begin
          full[b] <= 1'b1;
        end else if (release_bank && (rd_bank == 1'(b))) begin
          full[b] <= 1'b0;
        end
      end
    end
  end

  assign occupancy = {1'b0, full[0]} + {1'b0, full[1]};

  // ---------------------------------------------------------------------------
  // Read FSM. start_calc is a registered Moore output: it is high exactly
  // while the FSM sits in R_START.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= R_IDLE;
      rd_bank    <= 1'b0;
      start_calc <= 1'b0;
    end else begin
      start_calc <= 1'b0;
      unique case (rd_state)
        R_IDLE: begin
          if (full[rd_bank]) begin
            rd_state   <= R_START;
            start_calc <= 1'b1;
          end
        end
        R_START: begin
          rd_state <= R_BUSY;
        end
        R_BUSY: begin
          if (done_calc) begin
            rd_bank  <= ~rd_bank;
            rd_state <= R_IDLE;
          end
        end
        default: begin
          rd_state <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Banks and read mux
  // ---------------------------------------------------------------------------
  logic signed [N-1:0] bank_rd_r [2];
  logic signed [N-1:0] bank_rd_i [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    cmat_bank #(
      .N(N)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (accept && (wr_bank == 1'(b))),
      .waddr   (wr_ptr),
      .wdata_r (s_data_r),
      .wdata_i (s_data_i),
      .raddr   (rd_addr),
      .rdata_r (bank_rd_r[b]),
      .rdata_i (bank_rd_i[b])
    );
  end

  assign rd_data_r = bank_rd_r[rd_bank];
  assign rd_data_i = bank_rd_i[rd_bank];

endmodule

// File: tb/tb_cmat_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// tb_cmat_pingpong_buffer
//   Scoreboard bench. The writer pushes each committed matrix (and its commit
//   cycle) into a queue; a calculator model pops it on start_calc, reads all
//   eight entries back and releases the bank. A monitor compares occupancy,
//   s_ready and err_frame every cycle against counts kept by the model.
// -----------------------------------------------------------------------------
module tb_cmat_pingpong_buffer;
  import cmat_pkg::*;

  localparam int N = 16;

  typedef logic [7:0][31:0] frame_t;  // entry k = {real, imag}
  typedef enum int {C_IDLE, C_READ, C_WAIT} calc_e;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic signed [N-1:0] s_data_r = '0;
  logic signed [N-1:0] s_data_i = '0;
  logic                s_last = 1'b0;
  cmat_addr_t          rd_addr = '0;
  logic signed [N-1:0] rd_data_r;
  logic signed [N-1:0] rd_data_i;
  logic                start_calc;
  logic                done_calc = 1'b0;
  logic [1:0]          occupancy;
  logic                err_frame;

  cmat_pingpong_buffer #(.N(N), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data_r   (s_data_r),
    .s_data_i   (s_data_i),
    .s_last     (s_last),
    .rd_addr    (rd_addr),
    .rd_data_r  (rd_data_r),
    .rd_data_i  (rd_data_i),
    .start_calc (start_calc),
    .done_calc  (done_calc),
    .occupancy  (occupancy),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  frame_t q_data [$];
  int     q_cyc  [$];
  frame_t cur;
  int     wr_idx    = 0;
  int     commits   = 0;   // written by the writer only
  int     releases  = 0;   // written by the calculator only
  int     err_cyc   = -100;
  int     last_rel  = -100;
  int     done_req  = 0;
  int     done_ack  = 0;
  bit     hold_done = 1'b0;
  bit     mon_en    = 1'b0;
  calc_e  calc_st   = C_IDLE;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: bank counts and the error pulse
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("occupancy", {30'd0, occupancy}, commits - releases);
      check("s_ready", {31'd0, s_ready}, {31'd0, (commits - releases) < 2});
      check("err_frame", {31'd0, err_frame}, {31'd0, cyc == err_cyc + 1});
    end
  end

  // ---------------------------------------------------------------------------
  // Calculator model: waits for start_calc, reads all entries, releases.
  // A frame may start no earlier than two cycles after its commit and two
  // cycles after the previous release.
  // ---------------------------------------------------------------------------
  initial begin : calc
    int     idx;
    int     delay;
    int     exp_start;
    bit     rel_flag;
    frame_t f;
    idx = 0; delay = 0; rel_flag = 1'b0; f = '0;
    forever begin
      @(posedge clk); #2;
      if (rel_flag) begin
        releases++;
        rel_flag = 1'b0;
      end
      done_calc = 1'b0;
      case (calc_st)
        C_IDLE: begin
          rd_addr = cyc[2:0];
          if (done_req != done_ack) begin  // spurious done while idle
            done_ack++;
            done_calc = 1'b1;
          end
        end
        C_READ: rd_addr = cmat_addr(idx[2:1], idx[0]);
        C_WAIT: begin
          if (hold_done ? (done_req != done_ack) : (delay == 0)) begin
            if (hold_done) done_ack++;
            done_calc = 1'b1;
            last_rel  = cyc;
            rel_flag  = 1'b1;
            calc_st   = C_IDLE;
          end else if (!hold_done) begin
            delay--;
          end
        end
        default: calc_st = C_IDLE;
      endcase
      @(negedge clk);
      if (mon_en) begin
        exp_start = -1;
        if (calc_st == C_IDLE && q_cyc.size() > 0)
          exp_start = (q_cyc[0] > last_rel) ? q_cyc[0] + 2 : last_rel + 2;
        check("start_calc", {31'd0, start_calc}, {31'd0, cyc == exp_start});
        if (start_calc === 1'b1 && calc_st == C_IDLE && q_cyc.size() > 0) begin
          f = q_data.pop_front();
          void'(q_cyc.pop_front());
          idx = 0;
          calc_st = C_READ;
        end else if (calc_st == C_READ) begin
          check("rd_data_r", {16'd0, rd_data_r}, {16'd0, f[idx][31:16]});
          check("rd_data_i", {16'd0, rd_data_i}, {16'd0, f[idx][15:0]});
          idx++;
          if (idx == 8) begin
            calc_st = C_WAIT;
            delay = $urandom_range(0, 4);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Writer helpers (called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic beat(input bit v, input logic signed [15:0] r, input logic signed [15:0] im,
                      input bit last, output bit acc);
    int c;
    s_valid = v; s_data_r = r; s_data_i = im; s_last = last;
    @(negedge clk);
    acc = v && (s_ready === 1'b1);
    c = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (acc) begin
      if (wr_idx == 7 && last) begin
        cur[7] = {r, im};
        q_data.push_back(cur);
        q_cyc.push_back(c);
        commits++;
        wr_idx = 0;
      end else if (last || wr_idx == 7) begin
        err_cyc = c;
        wr_idx = 0;
      end else begin
        cur[wr_idx] = {r, im};
        wr_idx++;
      end
    end
  endtask

  task automatic wait_calc_wait();
    int t = 0;
    while (calc_st != C_WAIT) begin
      @(posedge clk); #1;
      if (++t > 500) begin
        timeout("calc_wait");
        break;
      end
    end
  endtask

  task automatic release_calc();
    wait_calc_wait();
    done_req++;
    idle(1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q_cyc.size() != 0 || calc_st != C_IDLE) begin
      @(posedge clk); #1;
      if (++t > 2000) begin
        timeout("drain");
        break;
      end
    end
    idle(3);
  endtask

  // nbeats beats of fd; s_last on beat last_pos (-1: none); done requested
  // together with beat done_at (-1: never).
  task automatic send_frame(input frame_t fd, input int nbeats, input int last_pos,
                            input int gap_max, input int done_at);
    bit acc;
    int tries;
    for (int b = 0; b < nbeats; b++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) beat(1'b0, '0, '0, 1'b0, acc);
      end
      if (b == done_at) begin
        wait_calc_wait();
        done_req++;
      end
      acc = 1'b0;
      tries = 0;
      while (!acc) begin
        beat(1'b1, fd[b][31:16], fd[b][15:0], b == last_pos, acc);
        if (!acc && ++tries > 300) begin
          timeout("write_beat");
          break;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    frame_t fa, fb, fr;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rd_data_r after reset", {16'd0, rd_data_r}, 32'd0);
      check("rd_data_i after reset", {16'd0, rd_data_i}, 32'd0);
      @(posedge clk); #1;
    end

    // Two frames, calculator holds the first one: both banks fill.
    hold_done = 1'b1;
    for (int k = 0; k < 8; k++) begin
      fa[k] = {16'(k + 1), 16'(-(k + 1))};
      fb[k] = {16'(100 + k), 16'(k)};
    end
    send_frame(fa, 8, 7, 0, -1);
    send_frame(fb, 8, 7, 0, -1);
    idle(3);
    check("occupancy both full", {30'd0, occupancy}, 32'd2);
    check("s_ready both full", {31'd0, s_ready}, 32'd0);
    release_calc();
    release_calc();
    wait_drain();

    // Misplaced s_last: early, then missing on beat 8.
    hold_done = 1'b0;
    for (int k = 0; k < 8; k++) fr[k] = {16'(200 + k), 16'(-k)};
    send_frame(fr, 4, 3, 0, -1);
    idle(4);
    check("occupancy after bad frame", {30'd0, occupancy}, 32'd0);
    send_frame(fr, 8, -1, 1, -1);
    idle(4);
    send_frame(fa, 8, 7, 1, -1);
    wait_drain();

    // Commit of bank 1 and release of bank 0 in the same cycle.
    hold_done = 1'b1;
    send_frame(fb, 8, 7, 0, -1);
    send_frame(fa, 8, 7, 0, 7);
    release_calc();
    wait_drain();
    hold_done = 1'b0;

    // Reset in the middle of a frame.
    send_frame(fb, 3, -1, 0, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    commits = releases;
    wr_idx  = 0;
    err_cyc = -100;
    q_data.delete();
    q_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rd_data_r after mid-frame reset", {16'd0, rd_data_r}, 32'd0);
      @(posedge clk); #1;
    end
    send_frame(fr, 8, 7, 0, -1);
    wait_drain();

    // done_calc with nothing started.
    done_req++;
    idle(6);
    check("occupancy after idle done", {30'd0, occupancy}, 32'd0);

    // Random traffic with occasional framing errors.
    for (int n = 0; n < 40; n++) begin
      int nb;
      for (int k = 0; k < 8; k++) fr[k] = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        nb = $urandom_range(1, 8);
        send_frame(fr, nb, (nb == 8) ? -1 : nb - 1, 2, -1);
      end else begin
        send_frame(fr, 8, 7, 2, -1);
      end
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
